ocp2sram: RTL
=============

Name: ocp2sram

Overview:
- OCP slave (responder) placed between the OCP interconnect and a single-port synchronous SRAM. It is the far end of the bus driven by the CPU instruction/data bus masters.
- Accepts one OCP command at a time and range-checks the address against its window.
- Performs the SRAM access, inserts configurable wait states, and returns a one-cycle OCP response.

Parameters:
- BASE_ADDR, 32'h0000_0000, byte base address of the SRAM window; aligned to the window size.
- SRAM_AWIDTH, 12, SRAM word-address width; window is 4*2^SRAM_AWIDTH bytes.
- WAIT_STATES, 0, extra cycles inserted before the response; range 0..15.

Ports:
- clk  in  1  clock
- nrst  in  1  asynchronous active-low reset
- i_MAddr  in  `ADDR_WIDTH  OCP byte address
- i_MCmd  in  3  OCP command
- i_MData  in  `DATA_WIDTH  OCP write data
- i_MByteEn  in  `BEN_WIDTH  OCP byte enables
- o_SCmdAccept  out  1  command accepted this cycle
- o_SData  out  `DATA_WIDTH  read response data
- o_SResp  out  2  OCP response
- o_SramAddr  out  SRAM_AWIDTH  SRAM word address
- o_SramCE  out  1  SRAM chip enable
- o_SramWE  out  1  SRAM write enable
- o_SramBE  out  `BEN_WIDTH  SRAM byte write enables
- o_SramData  out  `DATA_WIDTH  SRAM write data
- i_SramData  in  `DATA_WIDTH  SRAM read data, valid the cycle after a read with CE=1

Behaviour:
- Clock and reset: one clock, clk. Reset nrst is asynchronous, active-low.
- Reset values: state IDLE; o_SResp=`OCP_RESP_NULL; o_SData, o_SramAddr, o_SramBE and o_SramData are 0; o_SramCE and o_SramWE are 0. Reset asserted mid-transaction aborts it; no response is issued.
- o_SCmdAccept is combinational: 1 only when state==IDLE and i_MCmd!=`OCP_CMD_IDLE.
- Accept edge: address, data, byte enables and command are latched. The request is in range when i_MAddr[`ADDR_WIDTH-1:SRAM_AWIDTH+2]==BASE_ADDR[same bits]. i_MAddr[1:0] is ignored.
- States:
  - IDLE: on accept of an in-range READ or WRITE, go to ACCESS. On out-of-range, or any command other than READ/WRITE, load o_SResp=`OCP_RESP_ERR and o_SData=0, then go to RESP.
  - ACCESS, one cycle: o_SramCE=1 and o_SramAddr=i_MAddr[SRAM_AWIDTH+1:2].
    - READ: o_SramWE=0; load wait counter=WAIT_STATES; go to WAIT.
    - WRITE: o_SramWE=1, o_SramBE=latched i_MByteEn, o_SramData=latched i_MData. Next state depends on the optional feature.
  - WAIT: counter decrements each cycle. When the counter is 0, capture o_SData=i_SramData (READ only; 0 for WRITE), load o_SResp=`OCP_RESP_DVA, and go to RESP. WAIT lasts WAIT_STATES+1 cycles.
  - RESP, one cycle: o_SResp held. On exit, o_SResp returns to NULL and the state goes to IDLE.
- SRAM strobes are 0 outside ACCESS.
- The master holds i_MCmd through the response cycle. Commands present in RESP are not accepted; the next accept is possible in the cycle after RESP.
- Read latency: accept in cycle 0, CE in cycle 1, o_SResp=DVA in cycle 3+WAIT_STATES.
- Error latency: o_SResp=ERR in cycle 1. An ERR never touches the SRAM.

Optional Feature:
- Macro: OCP2SRAM_WRITE_RESP_EN.
- Defined: in-range writes go ACCESS->WAIT->RESP and return DVA with o_SData=0, with the same latency as a read.
- Undefined: writes are posted. ACCESS->IDLE, o_SResp stays NULL, and the next accept can occur in cycle 2.
- Out-of-range writes return ERR in both builds.

Decomposition:
- The shared package/include holds: `OCP_CMD_* / `OCP_RESP_* constants (ocp_const.vh), `ADDR_WIDTH / `DATA_WIDTH / `BEN_WIDTH (common.vh), and local state encodings as localparams.
- No sub-module; the wait counter and FSM are a single block.

Test Plan:
- Write 32'hDEADBEEF to 0x10 with BE=4'hF, then read 0x10 (WAIT_STATES=0) -> SRAM addr 4, o_SResp=DVA in cycle 3 for exactly one cycle, o_SData=32'hDEADBEEF.
- WAIT_STATES=3, read 0x20 -> DVA in cycle 6; o_SCmdAccept=0 in cycles 1..6 while i_MCmd is held.
- Read 0x4000 (outside the 16 KiB window, BASE_ADDR=0) -> ERR in cycle 1, o_SData=0, o_SramCE never asserted.
- Write 0x8 with BE=4'b0010 and data 32'h0000AB00 over 32'h11223344 -> a subsequent read returns 32'h1122AB44. With OCP2SRAM_WRITE_RESP_EN the write returns DVA; without it, o_SResp stays NULL.
- Back-to-back reads with i_MCmd held continuously -> exactly one accept per transaction; the second accept comes in the cycle after RESP.
- nrst pulsed low during WAIT -> all outputs go to reset values immediately, no response is issued, and the next command is accepted normally.

Source files
------------

// File: rtl/ocp2sram_pkg.sv
// Shared constants for the OCP-to-SRAM responder: bus widths, OCP command and
// response encodings, and the local FSM state encoding.
package ocp2sram_pkg;

    localparam int ADDR_WIDTH = 32;
    localparam int DATA_WIDTH = 32;
    localparam int BEN_WIDTH  = DATA_WIDTH / 8;

    localparam logic [2:0] OCP_CMD_IDLE  = 3'd0;
    localparam logic [2:0] OCP_CMD_WRITE = 3'd1;
    localparam logic [2:0] OCP_CMD_READ  = 3'd2;

    localparam logic [1:0] OCP_RESP_NULL = 2'd0;
    localparam logic [1:0] OCP_RESP_DVA  = 2'd1;
    localparam logic [1:0] OCP_RESP_FAIL = 2'd2;
    localparam logic [1:0] OCP_RESP_ERR  = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_WAIT   = 2'd2,
        ST_RESP   = 2'd3
    } state_t;

endpackage

// File: rtl/ocp2sram.sv
// OCP responder in front of a single-port synchronous SRAM. One command in
// flight, window range check, WAIT_STATES extra cycles before a one-cycle
// response. Optional macro OCP2SRAM_WRITE_RESP_EN: writes return DVA like
// reads; without it writes are posted and return no response.
module ocp2sram
    import ocp2sram_pkg::*;
#(
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = '0,
    parameter int                    SRAM_AWIDTH = 12,
    parameter int                    WAIT_STATES = 0
) (
    input  logic                   clk,
    input  logic                   nrst,
    input  logic [ADDR_WIDTH-1:0]  i_MAddr,
    input  logic [2:0]             i_MCmd,
    input  logic [DATA_WIDTH-1:0]  i_MData,
    input  logic [BEN_WIDTH-1:0]   i_MByteEn,
    output logic                   o_SCmdAccept,
    output logic [DATA_WIDTH-1:0]  o_SData,
    output logic [1:0]             o_SResp,
    output logic [SRAM_AWIDTH-1:0] o_SramAddr,
    output logic                   o_SramCE,
    output logic                   o_SramWE,
    output logic [BEN_WIDTH-1:0]   o_SramBE,
    output logic [DATA_WIDTH-1:0]  o_SramData,
    input  logic [DATA_WIDTH-1:0]  i_SramData
);

    state_t     state, state_nxt;
    logic       wr_q;        // latched command was a WRITE
    logic [3:0] wait_cnt;
    logic       in_range;
    logic       is_rd, is_wr;
    logic       go_access;

    // Byte offset within a word is irrelevant to a word-wide SRAM.
    logic unused_addr_lsb;
    assign unused_addr_lsb = ^i_MAddr[1:0];

    assign o_SCmdAccept = (state == ST_IDLE) && (i_MCmd != OCP_CMD_IDLE);
    assign in_range  = i_MAddr[ADDR_WIDTH-1:SRAM_AWIDTH+2] == BASE_ADDR[ADDR_WIDTH-1:SRAM_AWIDTH+2];
    assign is_rd     = (i_MCmd == OCP_CMD_READ);
    assign is_wr     = (i_MCmd == OCP_CMD_WRITE);
    assign go_access = in_range && (is_rd || is_wr);

    // State register.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) state <= ST_IDLE;
        else       state <= state_nxt;
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (o_SCmdAccept) state_nxt = go_access ? ST_ACCESS : ST_RESP;
            end
            ST_ACCESS: begin
`ifdef OCP2SRAM_WRITE_RESP_EN
                state_nxt = ST_WAIT;
`else
                // Posted writes skip the response entirely.
                state_nxt = wr_q ? ST_IDLE : ST_WAIT;
`endif
            end
            ST_WAIT: begin
                if (wait_cnt == 4'd0) state_nxt = ST_RESP;
            end
            ST_RESP:  state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    // Datapath: SRAM strobes are loaded on the accept edge so they are live
    // exactly during ACCESS, then cleared; response is loaded on entry to RESP.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            wr_q       <= 1'b0;
            wait_cnt   <= '0;
            o_SData    <= '0;
            o_SResp    <= OCP_RESP_NULL;
            o_SramAddr <= '0;
            o_SramCE   <= 1'b0;
            o_SramWE   <= 1'b0;
            o_SramBE   <= '0;
            o_SramData <= '0;
        end else begin
            o_SramCE <= 1'b0;
            o_SramWE <= 1'b0;
            o_SramBE <= '0;
            case (state)
                ST_IDLE: begin
                    if (o_SCmdAccept) begin
                        wr_q <= is_wr;
                        if (go_access) begin
                            o_SramCE   <= 1'b1;
                            o_SramWE   <= is_wr;
                            o_SramBE   <= is_wr ? i_MByteEn : '0;
                            o_SramAddr <= i_MAddr[SRAM_AWIDTH+1:2];
                            o_SramData <= i_MData;
                        end else begin
                            o_SResp <= OCP_RESP_ERR;
                            o_SData <= '0;
                        end
                    end
                end
                ST_ACCESS: wait_cnt <= 4'(WAIT_STATES);
                ST_WAIT: begin
                    if (wait_cnt == 4'd0) begin
                        o_SData <= wr_q ? '0 : i_SramData;
                        o_SResp <= OCP_RESP_DVA;
                    end else begin
                        wait_cnt <= wait_cnt - 4'd1;
                    end
                end
                ST_RESP:  o_SResp <= OCP_RESP_NULL;
                default:  o_SResp <= OCP_RESP_NULL;
            endcase
        end
    end

endmodule
